// File: rtl/ewb_fifo_buffer_if.sv
// L2-side and pmem-side handshake bundle for the eviction write buffer.
// The buffer uses the slave view; the L2/pmem environment uses the master view.
interface ewb_fifo_buffer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 256
);
  logic              l2_pmem_write;
  logic [ADDR_W-1:0] l2_pmem_waddress;
  logic [LINE_W-1:0] l2_pmem_wdata;
  logic              l2_pmem_read;
  logic [ADDR_W-1:0] l2_pmem_raddress;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  l2_pmem_write, l2_pmem_waddress, l2_pmem_wdata, l2_pmem_read, l2_pmem_raddress,
    output l2_resp, l2_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output l2_pmem_write, l2_pmem_waddress, l2_pmem_wdata, l2_pmem_read, l2_pmem_raddress,
    input  l2_resp, l2_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/ewb_fifo_buffer.sv
// Multi-entry eviction write buffer: queues dirty L2 lines, coalesces rewrites, forwards
// reads from queued lines and drains to pmem in FIFO order, with read misses taking priority.
module ewb_fifo_buffer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  ewb_fifo_buffer_if.slave             bus,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              resp_q, resp_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic             wr_req, rd_req, full_w, alloc, pop;
  logic             co_hit, rd_hit;
  logic [PTR_W-1:0] co_idx, rd_idx, rd_scan;

  // Requests are ignored in the l2_resp cycle so a still-held request is not taken twice.
  assign wr_req = bus.l2_pmem_write && !resp_q;
  assign rd_req = bus.l2_pmem_read && !bus.l2_pmem_write && !resp_q;
  assign full_w = (count_q == CNT_W'(DEPTH));
  assign pop    = (state_q == StDrain) && bus.pmem_resp;

  always_comb begin
    co_hit  = 1'b0;
    co_idx  = '0;
    rd_hit  = 1'b0;
    rd_idx  = '0;
    rd_scan = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.l2_pmem_waddress) &&
          !((state_q == StDrain) && (PTR_W'(i) == head_q))) begin
        co_hit = 1'b1;
        co_idx = PTR_W'(i);
      end
    end
    // Scan oldest to youngest so the last match is the youngest copy.
    for (int k = 0; k < DEPTH; k++) begin
      rd_scan = head_q + PTR_W'(k);
      if (valid_q[rd_scan] && (addr_q[rd_scan] == bus.l2_pmem_raddress)) begin
        rd_hit = 1'b1;
        rd_idx = rd_scan;
      end
    end
  end

  assign alloc = wr_req && !co_hit && !full_w;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    data_d       = data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    resp_d       = 1'b0;
    rdata_d      = rdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;

    if (wr_req && co_hit) begin
      data_d[co_idx] = bus.l2_pmem_wdata;
      resp_d         = 1'b1;
    end else if (alloc) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.l2_pmem_waddress;
      data_d[tail_q]  = bus.l2_pmem_wdata;
      tail_d          = tail_q + PTR_W'(1);
      resp_d          = 1'b1;
    end

    if (rd_req && rd_hit && (state_q != StRead)) begin
      rdata_d = data_q[rd_idx];
      resp_d  = 1'b1;
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

    unique case (state_q)
      StIdle: begin
        if (rd_req && !rd_hit) begin
          state_d     = StRead;
          pmem_read_d = 1'b1;
          pmem_addr_d = bus.l2_pmem_raddress;
        end else if (count_q != '0) begin
          state_d      = StDrain;
          pmem_write_d = 1'b1;
          pmem_addr_d  = addr_q[head_q];
          // Take post-coalesce data in case the head is rewritten this very cycle.
          pmem_wdata_d = data_d[head_q];
        end
      end
      StRead: begin
        if (bus.pmem_resp) begin
          rdata_d     = bus.pmem_rdata;
          resp_d      = 1'b1;
          pmem_read_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        if (bus.pmem_resp) begin
          pmem_write_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_q       <= 1'b0;
      rdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
    end
  end

  // Line storage is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign bus.l2_resp      = resp_q;
  assign bus.l2_rdata     = rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_addr_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign full             = full_w;
  assign empty            = (count_q == '0);
  assign count            = count_q;
endmodule

// File: tb/tb_ewb_fifo_buffer.sv
// Directed bench for ewb_fifo_buffer: a vector table of L2 transactions with pmem held off,
// then hand sequences for stall/drain, reset, coalescing, forwarding and read priority.
module tb_ewb_fifo_buffer;
  logic       clk;
  logic       rst;
  logic       full, empty;
  logic [2:0] count;

  ewb_fifo_buffer_if #(.ADDR_W(16), .LINE_W(256)) bus ();

  ewb_fifo_buffer #(.ADDR_W(16), .LINE_W(256), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  // pmem responder: serves while served < pmem_allow; logs every completed transaction.
  int             pmem_allow = 0;
  int             served     = 0;
  logic           log_rd [$];
  logic [15:0]    log_a  [$];
  logic [255:0]   log_d  [$];
  int             both_hi    = 0;
  int             rd_cycles  = 0;

  function automatic logic [255:0] mk(input int n);
    logic [31:0] w;
    w = {16'hC0DE, n[15:0]};
    return {8{w}};
  endfunction

  function automatic logic [255:0] rd_pat(input logic [15:0] a);
    logic [31:0] w;
    w = {16'hBEEF, a};
    return {8{w}} ^ 256'h1;
  endfunction

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (!rst && (bus.pmem_read || bus.pmem_write) && (served < pmem_allow)) begin
        log_rd.push_back(bus.pmem_read);
        log_a.push_back(bus.pmem_address);
        log_d.push_back(bus.pmem_read ? rd_pat(bus.pmem_address) : bus.pmem_wdata);
        if (bus.pmem_read) bus.pmem_rdata = rd_pat(bus.pmem_address);
        bus.pmem_resp = 1'b1;
        served++;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.pmem_read && bus.pmem_write) both_hi <= both_hi + 1;
    if (bus.pmem_read) rd_cycles <= rd_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [255:0] d, input int budget,
                          output logic got);
    bus.l2_pmem_write    = 1'b1;
    bus.l2_pmem_waddress = a;
    bus.l2_pmem_wdata    = d;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clk);
      #1;
      if (bus.l2_resp) got = 1'b1;
    end
    bus.l2_pmem_write = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input int budget, output logic got,
                         output logic [255:0] d, output int cyc);
    bus.l2_pmem_read     = 1'b1;
    bus.l2_pmem_raddress = a;
    got = 1'b0;
    d   = '0;
    cyc = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.l2_resp) begin
        got = 1'b1;
        d   = bus.l2_rdata;
      end
    end
    bus.l2_pmem_read = 1'b0;
  endtask

  task automatic wait_drained(input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #1;
      if (empty && !bus.pmem_write && !bus.pmem_read) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  dn;
    logic        exp_resp;
    logic [7:0]  exp_dn;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic         got, ok;
    logic [255:0] rd;
    int           cyc, base, rc0;

    vecs[0]  = '{1'b1, 16'h0100, 8'd1, 1'b1, 8'd0, 3'd1};  // becomes busy head
    vecs[1]  = '{1'b1, 16'h0200, 8'd2, 1'b1, 8'd0, 3'd2};
    vecs[2]  = '{1'b1, 16'h0200, 8'd3, 1'b1, 8'd0, 3'd2};  // coalesce
    vecs[3]  = '{1'b0, 16'h0200, 8'd0, 1'b1, 8'd3, 3'd2};  // hit coalesced data
    vecs[4]  = '{1'b0, 16'h0100, 8'd0, 1'b1, 8'd1, 3'd2};  // hit busy entry
    vecs[5]  = '{1'b1, 16'h0100, 8'd4, 1'b1, 8'd0, 3'd3};  // busy -> allocate
    vecs[6]  = '{1'b0, 16'h0100, 8'd0, 1'b1, 8'd4, 3'd3};  // youngest wins
    vecs[7]  = '{1'b1, 16'h0300, 8'd5, 1'b1, 8'd0, 3'd4};  // now full
    vecs[8]  = '{1'b1, 16'h0400, 8'd6, 1'b0, 8'd0, 3'd4};  // stalled
    vecs[9]  = '{1'b1, 16'h0300, 8'd7, 1'b1, 8'd0, 3'd4};  // coalesce while full
    vecs[10] = '{1'b0, 16'h0300, 8'd0, 1'b1, 8'd7, 3'd4};

    bus.l2_pmem_write    = 1'b0;
    bus.l2_pmem_read     = 1'b0;
    bus.l2_pmem_waddress = '0;
    bus.l2_pmem_raddress = '0;
    bus.l2_pmem_wdata    = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_l2_resp", bus.l2_resp, 0);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_l2_rdata", bus.l2_rdata, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    rst = 1'b0;

    // Table: pmem never answers, so the first line stays busy in DRAIN throughout.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, mk(int'(vecs[i].dn)), 8, got);
      end else begin
        do_read(vecs[i].addr, 8, got, rd, cyc);
        if (vecs[i].exp_resp) check($sformatf("vec%0d_rdata", i), rd, mk(int'(vecs[i].exp_dn)));
      end
      check($sformatf("vec%0d_resp", i), got, vecs[i].exp_resp);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
    end
    check("tbl_full", full, 1);
    check("tbl_drain_addr", bus.pmem_address, 16'h0100);
    check("tbl_drain_wdata", bus.pmem_wdata, mk(1));
    check("tbl_no_pmem_read", rd_cycles, 0);

    // Full, stalled write admitted once the head drains.
    pmem_allow = served + 1;
    do_write(16'h0400, mk(6), 12, got);
    check("stall_then_accept", got, 1);
    check("stall_count", count, 4);
    check("stall_drained_addr", log_a[log_a.size()-1], 16'h0100);

    // Reset while draining with three entries queued.
    pmem_allow = served + 1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (count == 3) ok = 1'b1;
    end
    check("pre_rst_count3", ok, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_draining", bus.pmem_write, 1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_pmem_write", bus.pmem_write, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_l2_resp", bus.l2_resp, 0);
    pmem_allow = served;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Coalesce into a non-busy line: only the newest data is drained, once.
    do_write(16'h0F00, mk(16'h10), 8, got);
    do_write(16'h1000, mk(16'h11), 8, got);
    do_write(16'h1000, mk(16'h12), 8, got);
    check("coal_resp", got, 1);
    check("coal_count", count, 2);
    base = log_a.size();
    pmem_allow = served + 1000;
    wait_drained(40, ok);
    check("coal_drained", ok, 1);
    check("coal_n_drains", log_a.size() - base, 2);
    if (log_a.size() - base == 2) begin
      check("coal_addr0", log_a[base], 16'h0F00);
      check("coal_addr1", log_a[base+1], 16'h1000);
      check("coal_data1", log_d[base+1], mk(16'h12));
    end

    // Rewrite of the busy line allocates; both versions drain in order.
    pmem_allow = served;
    do_write(16'h2000, mk(16'h21), 8, got);
    do_write(16'h2000, mk(16'h22), 8, got);
    check("busy_count", count, 2);
    base = log_a.size();
    pmem_allow = served + 1000;
    wait_drained(40, ok);
    check("busy_drained", ok, 1);
    check("busy_n_drains", log_a.size() - base, 2);
    if (log_a.size() - base == 2) begin
      check("busy_d0", log_d[base], mk(16'h21));
      check("busy_d1", log_d[base+1], mk(16'h22));
    end

    // Read forwarded from a queued line: one-cycle response, no pmem read.
    pmem_allow = served;
    do_write(16'h0F00, mk(16'h30), 8, got);
    do_write(16'h2000, mk(16'h35), 8, got);
    @(posedge clk);
    #1;
    rc0 = rd_cycles;
    do_read(16'h2000, 8, got, rd, cyc);
    check("fwd_resp", got, 1);
    check("fwd_latency", cyc, 1);
    check("fwd_rdata", rd, mk(16'h35));
    @(posedge clk);
    #1;
    check("fwd_no_pmem_read", rd_cycles - rc0, 0);

    // Read miss with two lines queued behind the drain: READ goes before the next DRAIN.
    do_write(16'h4000, mk(16'h40), 8, got);
    check("miss_pre_count", count, 3);
    base = log_a.size();
    pmem_allow = served + 1000;
    do_read(16'h3000, 30, got, rd, cyc);
    check("miss_resp", got, 1);
    check("miss_rdata", rd, rd_pat(16'h3000));
    wait_drained(40, ok);
    check("miss_drained", ok, 1);
    check("miss_n_txn", log_a.size() - base, 4);
    if (log_a.size() - base == 4) begin
      check("miss_t0_addr", log_a[base], 16'h0F00);
      check("miss_t1_isread", log_rd[base+1], 1);
      check("miss_t1_addr", log_a[base+1], 16'h3000);
      check("miss_t2_data", log_d[base+2], mk(16'h35));
      check("miss_t3_addr", log_a[base+3], 16'h4000);
    end
    check("never_both_strobes", both_hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
